// File: rtl/lab3_pkg.sv
// Shared types and constants for the lab 3 adder/subtractor front end.
package lab3_pkg;

  localparam int OPERAND_W = 4;

  // Operand-entry FSM states; the values double as the board LED pattern.
  typedef enum logic [1:0] {
    LOAD_A0 = 2'b00,
    LOAD_A1 = 2'b01,
    READY   = 2'b10
  } state_e;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and accepted level.
// Emits a one-cycle press pulse for every accepted release->press transition.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          key_s1_q, key_s2_q;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the raw button into the clock domain; idle level is released (1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
    end
  end

  // Until the button has been seen released for a full debounce window after
  // reset, a held key is ignored so reset release can never fake a press.
  // Once armed, the counter runs while the synced key disagrees with the
  // accepted level and reloads as soon as they agree again, so any glitch
  // shorter than the window is discarded.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (!armed_q) begin
      if (!key_s2_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        armed_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (key_s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      level_d = key_s2_q;
      cnt_d   = '0;
      press_d = ~key_s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
  assign level = level_q;

endmodule

// File: rtl/operand_entry.sv
// Operand entry front end: captures a0, then a1 plus add/sub select, on
// successive debounced button presses and holds them stable for the adder.
module operand_entry
  import lab3_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPERAND_W-1:0] sw,
  input  logic                 sub_sw,
  input  logic                 key_n,
  output logic [OPERAND_W-1:0] a0,
  output logic [OPERAND_W-1:0] a1,
  output logic                 s,
  output logic                 op_valid,
  output logic [1:0]           state_led
);

  logic [OPERAND_W-1:0] sw_s1_q, sw_s2_q;
  logic                 sub_s1_q, sub_s2_q;
  logic                 press;
  logic                 unused_level;

  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] a0_q, a0_d, a1_q, a1_d;
  logic                 s_q, s_d, op_valid_q, op_valid_d;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .press (press),
    .level (unused_level)
  );

  // Synchronize the slide switches; only the second stage is ever sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      sub_s1_q <= 1'b0;
      sub_s2_q <= 1'b0;
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      sub_s1_q <= sub_sw;
      sub_s2_q <= sub_s1_q;
    end
  end

  // Next-state and capture decisions; nothing moves except on a press.
  always_comb begin
    state_d    = state_q;
    a0_d       = a0_q;
    a1_d       = a1_q;
    s_d        = s_q;
    op_valid_d = op_valid_q;
    case (state_q)
      LOAD_A0: if (press) begin
        a0_d       = sw_s2_q;
        op_valid_d = 1'b0;
        state_d    = LOAD_A1;
      end
      LOAD_A1: if (press) begin
        a1_d       = sw_s2_q;
        s_d        = sub_s2_q;
        op_valid_d = 1'b1;
        state_d    = READY;
      end
      READY: if (press) begin
        // New entry; a1/s keep the previous set until overwritten.
        a0_d       = sw_s2_q;
        op_valid_d = 1'b0;
        state_d    = LOAD_A1;
      end
      default: state_d = LOAD_A0;
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD_A0;
      a0_q       <= '0;
      a1_q       <= '0;
      s_q        <= 1'b0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a0_q       <= a0_d;
      a1_q       <= a1_d;
      s_q        <= s_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign a0        = a0_q;
  assign a1        = a1_q;
  assign s         = s_q;
  assign op_valid  = op_valid_q;
  assign state_led = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a 4-cycle debounce window.
module tb_operand_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw = 4'h0;
  logic       sub_sw = 1'b0;
  logic       key_n = 1'b1;
  logic [3:0] a0, a1;
  logic       s, op_valid;
  logic [1:0] state_led;

  int checks = 0;
  int errors = 0;

  operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .sub_sw    (sub_sw),
    .key_n     (key_n),
    .a0        (a0),
    .a1        (a1),
    .s         (s),
    .op_valid  (op_valid),
    .state_led (state_led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (a0 !== 4'h0) begin errors++; $display("FAIL reset_a0 got %h want 0", a0); end
    checks++; if (a1 !== 4'h0) begin errors++; $display("FAIL reset_a1 got %h want 0", a1); end
    checks++; if ({s, op_valid} !== 2'b00) begin errors++; $display("FAIL reset_s_valid got %b want 00", {s, op_valid}); end
    checks++; if (state_led !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state_led); end
    tick(1);
    reset = 1'b0;
    tick(8);
  endtask

  task automatic test_full_entry;
    sw = 4'h5; sub_sw = 1'b0; key_n = 1'b0;
    tick(6);
    checks++; if ({state_led, a0} !== {2'b00, 4'h0}) begin errors++; $display("FAIL entry_early got state=%b a0=%h want 00/0", state_led, a0); end
    tick(1);
    checks++; if (a0 !== 4'h5) begin errors++; $display("FAIL entry_a0 got %h want 5", a0); end
    checks++; if ({state_led, op_valid} !== 3'b010) begin errors++; $display("FAIL entry_st1 got state=%b valid=%b want 01/0", state_led, op_valid); end
    key_n = 1'b1;
    tick(8);
    checks++; if (state_led !== 2'b01) begin errors++; $display("FAIL entry_release got %b want 01", state_led); end
    sw = 4'hA; sub_sw = 1'b1; key_n = 1'b0;
    tick(7);
    checks++; if (a1 !== 4'hA) begin errors++; $display("FAIL entry_a1 got %h want a", a1); end
    checks++; if ({s, op_valid} !== 2'b11) begin errors++; $display("FAIL entry_s_valid got %b want 11", {s, op_valid}); end
    checks++; if ({state_led, a0} !== {2'b10, 4'h5}) begin errors++; $display("FAIL entry_ready got state=%b a0=%h want 10/5", state_led, a0); end
    key_n = 1'b1;
    tick(8);
  endtask

  task automatic test_switch_independence;
    for (int i = 0; i < 6; i++) begin
      sw = 4'(i * 3);
      sub_sw = i[0];
      tick(3);
      checks++;
      if ({a0, a1, s, op_valid, state_led} !== {4'h5, 4'hA, 1'b1, 1'b1, 2'b10}) begin
        errors++;
        $display("FAIL sw_indep[%0d] got a0=%h a1=%h s=%b v=%b st=%b want 5/a/1/1/10", i, a0, a1, s, op_valid, state_led);
      end
    end
  endtask

  task automatic test_reentry;
    sw = 4'h3; sub_sw = 1'b0; key_n = 1'b0;
    tick(7);
    checks++; if ({a0, op_valid} !== {4'h3, 1'b0}) begin errors++; $display("FAIL reentry_a0 got a0=%h v=%b want 3/0", a0, op_valid); end
    checks++; if ({a1, s, state_led} !== {4'hA, 1'b1, 2'b01}) begin errors++; $display("FAIL reentry_hold got a1=%h s=%b st=%b want a/1/01", a1, s, state_led); end
    key_n = 1'b1;
    tick(8);
  endtask

  task automatic test_held_key;
    sw = 4'hC; sub_sw = 1'b0; key_n = 1'b0;
    tick(7);
    checks++; if ({a1, s, op_valid, state_led} !== {4'hC, 1'b0, 1'b1, 2'b10}) begin errors++; $display("FAIL held_capture got a1=%h s=%b v=%b st=%b want c/0/1/10", a1, s, op_valid, state_led); end
    sw = 4'h9;
    tick(100);
    checks++; if ({a0, a1, state_led} !== {4'h3, 4'hC, 2'b10}) begin errors++; $display("FAIL held_once got a0=%h a1=%h st=%b want 3/c/10", a0, a1, state_led); end
    key_n = 1'b1;
    tick(8);
  endtask

  task automatic test_bounce;
    int len [10] = '{1, 2, 3, 1, 2, 3, 1, 2, 3, 2};
    sw = 4'h6;
    for (int i = 0; i < 10; i++) begin
      key_n = i[0];
      tick(len[i]);
    end
    checks++; if ({a0, state_led} !== {4'h3, 2'b10}) begin errors++; $display("FAIL bounce_reject got a0=%h st=%b want 3/10", a0, state_led); end
    key_n = 1'b0;
    tick(7);
    checks++; if ({a0, op_valid, state_led} !== {4'h6, 1'b0, 2'b01}) begin errors++; $display("FAIL bounce_capture got a0=%h v=%b st=%b want 6/0/01", a0, op_valid, state_led); end
    tick(20);
    checks++; if ({a0, a1, state_led} !== {4'h6, 4'hC, 2'b01}) begin errors++; $display("FAIL bounce_single got a0=%h a1=%h st=%b want 6/c/01", a0, a1, state_led); end
    key_n = 1'b1;
    tick(8);
  endtask

  task automatic test_reset_mid_op;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if ({a0, a1, s, op_valid, state_led} !== 12'h0) begin errors++; $display("FAIL midreset_async got a0=%h a1=%h s=%b v=%b st=%b want all 0", a0, a1, s, op_valid, state_led); end
    key_n = 1'b0; sw = 4'hF;
    tick(3);
    reset = 1'b0;
    tick(20);
    checks++; if ({a0, state_led} !== {4'h0, 2'b00}) begin errors++; $display("FAIL midreset_held got a0=%h st=%b want 0/00", a0, state_led); end
    key_n = 1'b1;
    tick(10);
    checks++; if (state_led !== 2'b00) begin errors++; $display("FAIL midreset_release got %b want 00", state_led); end
    key_n = 1'b0;
    tick(7);
    checks++; if ({a0, state_led} !== {4'hF, 2'b01}) begin errors++; $display("FAIL midreset_newpress got a0=%h st=%b want f/01", a0, state_led); end
    key_n = 1'b1;
    tick(8);
  endtask

  initial begin
    test_reset;
    test_full_entry;
    test_switch_independence;
    test_reentry;
    test_held_key;
    test_bounce;
    test_reset_mid_op;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
